// File: rtl/quad_error_sense.sv
// ---------------------------------------------------------------------------
// quad_error_sense
//
// Feedback front end of the motor position loop. Decodes a quadrature
// encoder (A/B) into a signed, saturating position count and, once every
// SAMPLE_DIV clocks, presents the saturated position error
// (setpoint - position) to the PID block together with a one-cycle strobe.
//
// Parameters
//   W          : error width minus one; e_out is W+1 bits signed
//   POS_W      : position counter width (signed); must exceed W
//   FILT_LEN   : consecutive stable cycles before an encoder level is
//                accepted (1..15)
//   SAMPLE_DIV : clocks per error sample (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   enc_a     in   encoder channel A (asynchronous)
//   enc_b     in   encoder channel B (asynchronous)
//   zero      in   synchronous position clear (homing), wins over a step
//   setpoint  in   signed target position, sampled on the sample tick
//   e_out     out  signed saturated error, held between ticks
//   e_valid   out  one-cycle pulse when e_out updates
//   position  out  signed current count
//   dir       out  direction of last valid step (1 = up)
//   illegal   out  one-cycle pulse on an A/B transition that skips a state
//   err_cnt   out  saturating count of illegal transitions
// ---------------------------------------------------------------------------
module quad_error_sense #(
    parameter int W          = 11,
    parameter int POS_W      = 16,
    parameter int FILT_LEN   = 2,
    parameter int SAMPLE_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    zero,
    input  logic signed [POS_W-1:0] setpoint,
    output logic signed [W:0]       e_out,
    output logic                    e_valid,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    illegal,
    output logic [7:0]              err_cnt
);

    localparam int FCNT_W = 4;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);

    // The filter accepts a level on the cycle its run length would reach
    // FILT_LEN, so the counter's terminal value is FILT_LEN-1.
    localparam logic [FCNT_W-1:0] FILT_TERM = FCNT_W'(FILT_LEN - 1);
    localparam logic [DIV_W-1:0]  DIV_TERM  = DIV_W'(SAMPLE_DIV - 1);

    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    localparam logic signed [W:0] ERR_MAX = {1'b0, {W{1'b1}}};
    localparam logic signed [W:0] ERR_MIN = {1'b1, {W{1'b0}}};

    // Error limits widened to the subtraction width for comparison.
    localparam logic signed [POS_W:0] ERR_MAX_X = (POS_W+1)'((2**W) - 1);
    localparam logic signed [POS_W:0] ERR_MIN_X = (POS_W+1)'(-(2**W));

    // -----------------------------------------------------------------------
    // Saturating arithmetic helpers
    // -----------------------------------------------------------------------
    function automatic logic signed [POS_W-1:0] pos_inc(
        input logic signed [POS_W-1:0] p
    );
        return (p == POS_MAX) ? p : p + POS_ONE;
    endfunction

    function automatic logic signed [POS_W-1:0] pos_dec(
        input logic signed [POS_W-1:0] p
    );
        return (p == POS_MIN) ? p : p - POS_ONE;
    endfunction

    function automatic logic signed [W:0] sat_err(
        input logic signed [POS_W:0] d
    );
        if (d > ERR_MAX_X) begin
            return ERR_MAX;
        end else if (d < ERR_MIN_X) begin
            return ERR_MIN;
        end else begin
            return $signed(d[W:0]);
        end
    endfunction

    function automatic logic [7:0] cnt_inc_sat(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizers on the asynchronous pins
    // -----------------------------------------------------------------------
    logic a_sync_p0, a_sync_p1;
    logic b_sync_p0, b_sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_p0 <= 1'b0;
            a_sync_p1 <= 1'b0;
            b_sync_p0 <= 1'b0;
            b_sync_p1 <= 1'b0;
        end else begin
            a_sync_p0 <= enc_a;
            a_sync_p1 <= a_sync_p0;
            b_sync_p0 <= enc_b;
            b_sync_p1 <= b_sync_p0;
        end
    end

    // -----------------------------------------------------------------------
    // Level filter: a channel's accepted level changes only after the
    // synchronized level has disagreed with it for FILT_LEN straight cycles.
    // Any agreeing cycle restarts the run, so short glitches vanish.
    // -----------------------------------------------------------------------
    logic [FCNT_W-1:0] a_fcnt, b_fcnt;
    logic              a_filt, b_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_fcnt <= '0;
            a_filt <= 1'b0;
        end else if (a_sync_p1 == a_filt) begin
            a_fcnt <= '0;
        end else if (a_fcnt == FILT_TERM) begin
            a_filt <= a_sync_p1;
            a_fcnt <= '0;
        end else begin
            a_fcnt <= a_fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_fcnt <= '0;
            b_filt <= 1'b0;
        end else if (b_sync_p1 == b_filt) begin
            b_fcnt <= '0;
        end else if (b_fcnt == FILT_TERM) begin
            b_filt <= b_sync_p1;
            b_fcnt <= '0;
        end else begin
            b_fcnt <= b_fcnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p2: x4 decode of previous vs. current filtered state.
    // State is written {B,A}, so the up sequence 00-01-11-10 is A leading B.
    // -----------------------------------------------------------------------
    logic [1:0] ab_cur, ab_prev;
    logic       up_c, dn_c, bad_c;
    logic       up_p2, dn_p2, bad_p2;

    assign ab_cur = {b_filt, a_filt};

    always_comb begin
        up_c  = 1'b0;
        dn_c  = 1'b0;
        bad_c = 1'b0;
        case ({ab_prev, ab_cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up_c  = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dn_c  = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ab_prev <= 2'b00;
            up_p2   <= 1'b0;
            dn_p2   <= 1'b0;
            bad_p2  <= 1'b0;
        end else begin
            ab_prev <= ab_cur;
            up_p2   <= up_c;
            dn_p2   <= dn_c;
            bad_p2  <= bad_c;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p3: position counter, direction and error bookkeeping.
    // zero drops a coincident step but leaves dir/err_cnt to the decoder.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            position <= '0;
            dir      <= 1'b0;
            illegal  <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            illegal <= bad_p2;
            if (bad_p2) begin
                err_cnt <= cnt_inc_sat(err_cnt);
            end
            if (up_p2) begin
                dir <= 1'b1;
            end else if (dn_p2) begin
                dir <= 1'b0;
            end
            if (zero) begin
                position <= '0;
            end else if (up_p2) begin
                position <= pos_inc(position);
            end else if (dn_p2) begin
                position <= pos_dec(position);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sample divider and error register. The subtraction reads the position
    // register before this cycle's update, so a tick that coincides with a
    // step or with zero sees the old count. One extra bit keeps the
    // difference exact before it is clamped to the error range.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0]        div_cnt;
    logic signed [POS_W:0]   diff_c;

    assign diff_c = $signed({setpoint[POS_W-1], setpoint})
                  - $signed({position[POS_W-1], position});

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            e_valid <= 1'b0;
            e_out   <= '0;
        end else if (div_cnt == DIV_TERM) begin
            div_cnt <= '0;
            e_valid <= 1'b1;
            e_out   <= sat_err(diff_c);
        end else begin
            div_cnt <= div_cnt + 1'b1;
            e_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_error_sense.sv
// ---------------------------------------------------------------------------
// Testbench for quad_error_sense. A behavioural model runs alongside the DUT
// (sliding-window level acceptance, fixed pipeline delay, ring-index step
// classification, saturating counts). Expected errors are queued at each
// modelled sample tick and popped by a monitor whenever e_valid is seen.
// ---------------------------------------------------------------------------
module tb_quad_error_sense;

    localparam int W     = 11;
    localparam int PW    = 16;
    localparam int FL    = 2;
    localparam int SD    = 64;
    localparam int PMAX  = 32767;
    localparam int PMIN  = -32768;
    localparam int EMAX  = 2047;
    localparam int EMIN  = -2048;

    logic                 clk;
    logic                 reset;
    logic                 enc_a;
    logic                 enc_b;
    logic                 zero;
    logic signed [PW-1:0] setpoint;
    logic signed [W:0]    e_out;
    logic                 e_valid;
    logic signed [PW-1:0] position;
    logic                 dir;
    logic                 illegal;
    logic [7:0]           err_cnt;

    quad_error_sense #(
        .W(W), .POS_W(PW), .FILT_LEN(FL), .SAMPLE_DIV(SD)
    ) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .zero(zero),
        .setpoint(setpoint), .e_out(e_out), .e_valid(e_valid),
        .position(position), .dir(dir), .illegal(illegal), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int ill_cnt = 0;
    bit started = 0;

    // model state
    bit ha[0:FL];
    bit hb[0:FL];
    bit fa, fb;
    int pend1, pend2;          // 0 none, 1 up, 2 down, 3 illegal
    int mpos, mcnt, merr, meout;
    bit mdir, mill, mev;
    int q[$];

    function automatic int sat_e(input int d);
        if (d > EMAX) return EMAX;
        if (d < EMIN) return EMIN;
        return d;
    endfunction

    // position of a {B,A} state around the quadrature ring
    function automatic int ring_idx(input bit b, input bit a);
        case ({b, a})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int classify(input bit ob, input bit oa,
                                    input bit nb, input bit na);
        int d;
        d = (ring_idx(nb, na) - ring_idx(ob, oa) + 4) % 4;
        case (d)
            1:       return 1;
            3:       return 2;
            2:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model, evaluated at every rising edge
    initial begin
        forever begin
            @(posedge clk);
            started = 1;
            if (reset) begin
                for (int i = 0; i <= FL; i++) begin
                    ha[i] = 0;
                    hb[i] = 0;
                end
                fa = 0; fb = 0; pend1 = 0; pend2 = 0;
                mpos = 0; mcnt = 0; merr = 0; meout = 0;
                mdir = 0; mill = 0; mev = 0;
            end else begin
                bit na, nb, diff_a, diff_b;
                mev = 0;
                if (mcnt == SD - 1) begin
                    meout = sat_e(int'(setpoint) - mpos);
                    q.push_back(meout);
                    mev = 1;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
                mill = 0;
                if (pend2 == 1) begin
                    mdir = 1;
                    if (mpos < PMAX) mpos++;
                end else if (pend2 == 2) begin
                    mdir = 0;
                    if (mpos > PMIN) mpos--;
                end else if (pend2 == 3) begin
                    mill = 1;
                    if (merr < 255) merr++;
                end
                if (zero) mpos = 0;
                // a level is accepted once FL consecutive synchronized
                // samples all disagree with the current accepted level
                diff_a = 1;
                diff_b = 1;
                for (int i = 1; i <= FL; i++) begin
                    if (ha[i] == fa) diff_a = 0;
                    if (hb[i] == fb) diff_b = 0;
                end
                na = diff_a ? ~fa : fa;
                nb = diff_b ? ~fb : fb;
                pend2 = pend1;
                pend1 = classify(fb, fa, nb, na);
                fa = na;
                fb = nb;
                for (int i = FL; i >= 1; i--) begin
                    ha[i] = ha[i-1];
                    hb[i] = hb[i-1];
                end
                ha[0] = enc_a;
                hb[0] = enc_b;
            end
        end
    end

    // monitor: per-cycle status against the model, scoreboard on e_valid
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                total++;
                if ($isunknown({e_out, e_valid, position, dir, illegal, err_cnt}) ||
                    int'(position) != mpos || dir != mdir || illegal != mill ||
                    int'(err_cnt) != merr || e_valid != mev || int'(e_out) != meout) begin
                    bad++;
                    $display("FAIL status t=%0t got pos=%0d dir=%0b ill=%0b err=%0d ev=%0b eout=%0d expected pos=%0d dir=%0b ill=%0b err=%0d ev=%0b eout=%0d",
                             $time, position, dir, illegal, err_cnt, e_valid, e_out,
                             mpos, mdir, mill, merr, mev, meout);
                end
                if (e_valid === 1'b1) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_valid: got e_out=%0d expected no sample", e_out);
                    end else begin
                        int exp_e;
                        exp_e = q.pop_front();
                        if (int'(e_out) != exp_e) begin
                            bad++;
                            $display("FAIL sb_eout: got %0d expected %0d", e_out, exp_e);
                        end
                    end
                end
                if (illegal === 1'b1) ill_cnt++;
                if (bad >= 40) begin
                    summary();
                    $finish;
                end
            end
        end
    end

    initial begin
        #600000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    task automatic step(input bit fwd, input int hold);
        @(negedge clk);
        if (fwd == (enc_a == enc_b)) enc_a = ~enc_a;
        else enc_b = ~enc_b;
        repeat (hold) @(negedge clk);
    endtask

    task automatic both(input int hold);
        @(negedge clk);
        enc_a = ~enc_a;
        enc_b = ~enc_b;
        repeat (hold) @(negedge clk);
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            if (e_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("tick_seen", int'(ok), 1);
    endtask

    initial begin
        int cyc;
        int r;
        reset = 1; enc_a = 0; enc_b = 0; zero = 0; setpoint = '0;
        repeat (3) @(negedge clk);
        chk("rst_eout", int'(e_out), 0);
        chk("rst_evalid", int'(e_valid), 0);
        chk("rst_pos", int'(position), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_errcnt", int'(err_cnt), 0);
        reset = 0;

        // four forward cycles
        ill_cnt = 0;
        for (int i = 0; i < 16; i++) step(1, 19);
        repeat (10) @(negedge clk);
        chk("fwd_pos", int'(position), 16);
        chk("fwd_dir", int'(dir), 1);
        chk("fwd_no_illegal", ill_cnt, 0);
        wait_tick();
        chk("fwd_eout", int'(e_out), -16);
        @(negedge clk);
        chk("fwd_evalid_1cyc", int'(e_valid), 0);

        // three reverse edges
        for (int i = 0; i < 3; i++) step(0, 19);
        repeat (10) @(negedge clk);
        chk("rev_pos", int'(position), 13);
        chk("rev_dir", int'(dir), 0);
        setpoint = 16'sd20;
        wait_tick();
        chk("rev_eout", int'(e_out), 7);

        // one-cycle glitch on A
        ill_cnt = 0;
        @(negedge clk); enc_a = ~enc_a;
        @(negedge clk); enc_a = ~enc_a;
        repeat (12) @(negedge clk);
        chk("glitch_pos", int'(position), 13);
        chk("glitch_no_illegal", ill_cnt, 0);

        // back to 00, then jump straight to 11
        step(0, 12);
        ill_cnt = 0;
        both(12);
        chk("jump_illegal_pulses", ill_cnt, 1);
        chk("jump_errcnt", int'(err_cnt), 1);
        chk("jump_pos", int'(position), 12);

        // error clamping from position 0
        @(negedge clk); zero = 1;
        @(negedge clk); zero = 0;
        chk("zero_pos", int'(position), 0);
        setpoint = 16'sd3000;
        wait_tick();
        chk("sat_pos_eout", int'(e_out), 2047);
        setpoint = -16'sd3000;
        wait_tick();
        chk("sat_neg_eout", int'(e_out), -2048);

        // zero on the same edge a forward step lands
        step(1, 10);
        step(1, 10);
        chk("pre_zero_pos", int'(position), 2);
        step(1, 0);
        repeat (5) @(negedge clk);
        zero = 1;
        @(negedge clk);
        zero = 0;
        chk("zero_step_pos", int'(position), 0);
        repeat (10) @(negedge clk);
        chk("zero_step_dropped", int'(position), 0);

        // reset mid-run at position 50 with a step in flight
        @(negedge clk); zero = 1;
        @(negedge clk); zero = 0;
        for (int i = 0; i < 50; i++) step(1, 6);
        repeat (10) @(negedge clk);
        chk("pre_reset_pos", int'(position), 50);
        step(1, 2);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_eout", int'(e_out), 0);
        chk("mid_rst_evalid", int'(e_valid), 0);
        chk("mid_rst_pos", int'(position), 0);
        chk("mid_rst_dir", int'(dir), 0);
        chk("mid_rst_errcnt", int'(err_cnt), 0);
        reset = 0;
        cyc = 0;
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            cyc++;
            if (e_valid === 1'b1) break;
        end
        chk("first_tick_latency", cyc, SD);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, 8)));
            end else if (r < 78) begin
                both(int'($urandom_range(0, 8)));
            end else if (r < 88) begin
                int sp;
                @(negedge clk);
                sp = int'($urandom_range(0, 6000)) - 3000;
                setpoint = 16'(sp);
            end else if (r < 93) begin
                @(negedge clk); zero = 1;
                @(negedge clk); zero = 0;
            end else begin
                repeat (int'($urandom_range(10, 60))) @(negedge clk);
            end
        end

        // drive err_cnt into saturation
        for (int i = 0; i < 260; i++) both(5);
        repeat (10) @(negedge clk);
        chk("errcnt_sat", int'(err_cnt), 255);

        repeat (2 * SD) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        summary();
        $finish;
    end

endmodule
